// File: rtl/frog_collide_if.sv
// Frog/lane signal bundle for frog_collide; the invuln member exists only when FROG_INVULN_EN is defined.
interface frog_collide_if;
    logic [3:0]   frog_row;
    logic [3:0]   frog_col;
    logic [127:0] lane_pixels;
`ifdef FROG_INVULN_EN
    logic         invuln;
`endif
    logic         hit;
    logic         frog_respawn;
    logic         game_over;
    logic [1:0]   lives;

    modport master (
`ifdef FROG_INVULN_EN
        output invuln,
`endif
        output frog_row, frog_col, lane_pixels,
        input  hit, frog_respawn, game_over, lives
    );

    modport slave (
`ifdef FROG_INVULN_EN
        input  invuln,
`endif
        input  frog_row, frog_col, lane_pixels,
        output hit, frog_respawn, game_over, lives
    );
endinterface

// File: rtl/frog_collide.sv
// Frog/car collision detector with lives, respawn hold-off and game-over tracking.
// Optional macro FROG_INVULN_EN adds an invuln input that suppresses hits while in RUN.
module frog_collide #(
    parameter int LIVES          = 3,
    parameter int HIT_CYCLES     = 2,
    parameter int RESPAWN_CYCLES = 1024,
    parameter int LANE_BASE      = 8
) (
    input  logic          clk,
    input  logic          reset,
    frog_collide_if.slave bus
);
    typedef enum logic [1:0] {RUN, HIT, RESPAWN, DEAD} state_t;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_ovl_cnt, w_ovl_cnt_nxt;
    logic [15:0] r_resp_cnt, w_resp_cnt_nxt;
    logic [1:0]  r_lives, w_lives_nxt;

    logic [4:0]  w_row_off;
    logic        w_in_road;
    logic [6:0]  w_bit_idx;
    logic        w_overlap;
    logic        w_ovl_eff;

    // Borrow in bit 4 flags rows below the base; bit 3 flags rows past the eighth lane.
    assign w_row_off = {1'b0, bus.frog_row} - 5'(LANE_BASE);
    assign w_in_road = ~w_row_off[4] & ~w_row_off[3];
    assign w_bit_idx = {w_row_off[2:0], bus.frog_col};
    assign w_overlap = w_in_road & bus.lane_pixels[w_bit_idx];

`ifdef FROG_INVULN_EN
    assign w_ovl_eff = w_overlap & ~bus.invuln;
`else
    assign w_ovl_eff = w_overlap;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= RUN;
            r_ovl_cnt  <= '0;
            r_resp_cnt <= '0;
            r_lives    <= 2'(LIVES);
        end else begin
            r_state    <= w_state_nxt;
            r_ovl_cnt  <= w_ovl_cnt_nxt;
            r_resp_cnt <= w_resp_cnt_nxt;
            r_lives    <= w_lives_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_ovl_cnt_nxt  = r_ovl_cnt;
        w_resp_cnt_nxt = r_resp_cnt;
        w_lives_nxt    = r_lives;
        case (r_state)
            RUN: begin
                if (w_ovl_eff) begin
                    if (r_ovl_cnt == 4'(HIT_CYCLES - 1)) begin
                        w_state_nxt   = HIT;
                        w_ovl_cnt_nxt = '0;
                    end else begin
                        w_ovl_cnt_nxt = r_ovl_cnt + 4'd1;
                    end
                end else begin
                    w_ovl_cnt_nxt = '0;
                end
            end
            HIT: begin
                // Lives decrement on leaving HIT; the DEAD decision uses the value held on entry.
                if (r_lives != 2'd0) begin
                    w_lives_nxt = r_lives - 2'd1;
                end
                w_state_nxt = (r_lives <= 2'd1) ? DEAD : RESPAWN;
            end
            RESPAWN: begin
                if (r_resp_cnt == 16'(RESPAWN_CYCLES - 1)) begin
                    w_state_nxt    = RUN;
                    w_resp_cnt_nxt = '0;
                end else begin
                    w_resp_cnt_nxt = r_resp_cnt + 16'd1;
                end
            end
            DEAD: begin
                w_state_nxt = DEAD;
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    assign bus.hit          = (r_state != RUN);
    assign bus.frog_respawn = (r_state == RESPAWN);
    assign bus.game_over    = (r_state == DEAD);
    assign bus.lives        = r_lives;
endmodule

// File: tb/tb_frog_collide.sv
// Directed self-checking bench for frog_collide (default parameters; invuln scenario when FROG_INVULN_EN is defined).
module tb_frog_collide;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    frog_collide_if ifc();

    frog_collide #(
        .LIVES          (3),
        .HIT_CYCLES     (2),
        .RESPAWN_CYCLES (1024),
        .LANE_BASE      (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected below 2000000", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        ifc.lane_pixels = '0;
        cycles(2);
        reset = 1'b0;
    endtask

    // Frog at row 9 col 3 on a car in lane 1; leaves the DUT in HIT with the car removed.
    task automatic collide();
        ifc.frog_row = 4'd9;
        ifc.frog_col = 4'd3;
        ifc.lane_pixels = '0;
        ifc.lane_pixels[19] = 1'b1;
        cycles(2);
        ifc.lane_pixels = '0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (ifc.hit !== 1'b0) begin n_fail++; $display("FAIL reset_hit: got %b expected 0", ifc.hit); end
        n_checks++; if (ifc.frog_respawn !== 1'b0) begin n_fail++; $display("FAIL reset_respawn: got %b expected 0", ifc.frog_respawn); end
        n_checks++; if (ifc.game_over !== 1'b0) begin n_fail++; $display("FAIL reset_game_over: got %b expected 0", ifc.game_over); end
        n_checks++; if (ifc.lives !== 2'd3) begin n_fail++; $display("FAIL reset_lives: got %0d expected 3", ifc.lives); end
    endtask

    task automatic test_single_hit();
        do_reset();
        ifc.frog_row = 4'd9;
        ifc.frog_col = 4'd3;
        ifc.lane_pixels = '0;
        ifc.lane_pixels[19] = 1'b1;
        cycles(1);
        n_checks++; if (ifc.hit !== 1'b0) begin n_fail++; $display("FAIL single_first_overlap: hit got %b expected 0", ifc.hit); end
        cycles(1);
        ifc.lane_pixels = '0;
        n_checks++; if (ifc.hit !== 1'b1) begin n_fail++; $display("FAIL single_hit: hit got %b expected 1", ifc.hit); end
        n_checks++; if (ifc.frog_respawn !== 1'b0) begin n_fail++; $display("FAIL single_hit_respawn: got %b expected 0", ifc.frog_respawn); end
        cycles(1);
        n_checks++; if (ifc.frog_respawn !== 1'b1) begin n_fail++; $display("FAIL single_respawn_start: got %b expected 1", ifc.frog_respawn); end
        n_checks++; if (ifc.lives !== 2'd2) begin n_fail++; $display("FAIL single_lives: got %0d expected 2", ifc.lives); end
        cycles(1023);
        n_checks++; if (ifc.frog_respawn !== 1'b1 || ifc.hit !== 1'b1) begin n_fail++; $display("FAIL single_respawn_last: respawn/hit got %b%b expected 11", ifc.frog_respawn, ifc.hit); end
        cycles(1);
        n_checks++; if (ifc.frog_respawn !== 1'b0 || ifc.hit !== 1'b0) begin n_fail++; $display("FAIL single_back_to_run: respawn/hit got %b%b expected 00", ifc.frog_respawn, ifc.hit); end
        n_checks++; if (ifc.lives !== 2'd2) begin n_fail++; $display("FAIL single_lives_after: got %0d expected 2", ifc.lives); end
    endtask

    task automatic test_alternating();
        int bad;
        bad = 0;
        do_reset();
        ifc.frog_row = 4'd9;
        ifc.lane_pixels = '0;
        ifc.lane_pixels[19] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            // Frog hops on and off the car every cycle
            ifc.frog_col = (i % 2 == 0) ? 4'd3 : 4'd4;
            cycles(1);
            if (ifc.hit !== 1'b0) bad++;
        end
        ifc.lane_pixels = '0;
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL alt_no_hit: cycles with hit got %0d expected 0", bad); end
        n_checks++; if (ifc.lives !== 2'd3) begin n_fail++; $display("FAIL alt_lives: got %0d expected 3", ifc.lives); end
    endtask

    task automatic test_lane_bounds();
        int bad;
        bad = 0;
        do_reset();
        ifc.frog_row = 4'd5;
        ifc.frog_col = 4'd7;
        ifc.lane_pixels = '1;
        for (int i = 0; i < 100; i++) begin
            cycles(1);
            if (ifc.hit !== 1'b0) bad++;
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL nonroad_no_hit: cycles with hit got %0d expected 0", bad); end
        ifc.frog_row = 4'd7;
        cycles(3);
        n_checks++; if (ifc.hit !== 1'b0) begin n_fail++; $display("FAIL row7_no_hit: got %b expected 0", ifc.hit); end
        ifc.frog_row = 4'd15;
        ifc.frog_col = 4'd15;
        ifc.lane_pixels = '0;
        ifc.lane_pixels[127] = 1'b1;
        cycles(2);
        n_checks++; if (ifc.hit !== 1'b1) begin n_fail++; $display("FAIL row15_col15_hit: got %b expected 1", ifc.hit); end
        do_reset();
        ifc.frog_row = 4'd8;
        ifc.frog_col = 4'd0;
        ifc.lane_pixels = '0;
        ifc.lane_pixels[0] = 1'b1;
        cycles(2);
        n_checks++; if (ifc.hit !== 1'b1) begin n_fail++; $display("FAIL row8_col0_hit: got %b expected 1", ifc.hit); end
        ifc.lane_pixels = '0;
    endtask

    task automatic test_game_over();
        int bad;
        bad = 0;
        do_reset();
        collide();
        cycles(1);
        n_checks++; if (ifc.lives !== 2'd2) begin n_fail++; $display("FAIL go_lives1: got %0d expected 2", ifc.lives); end
        cycles(1024);
        collide();
        cycles(1);
        n_checks++; if (ifc.lives !== 2'd1) begin n_fail++; $display("FAIL go_lives2: got %0d expected 1", ifc.lives); end
        cycles(1024);
        collide();
        n_checks++; if (ifc.game_over !== 1'b0) begin n_fail++; $display("FAIL go_in_hit: game_over got %b expected 0", ifc.game_over); end
        cycles(1);
        n_checks++; if (ifc.lives !== 2'd0) begin n_fail++; $display("FAIL go_lives3: got %0d expected 0", ifc.lives); end
        n_checks++; if (ifc.game_over !== 1'b1 || ifc.hit !== 1'b1 || ifc.frog_respawn !== 1'b0) begin n_fail++; $display("FAIL go_dead_outputs: game_over/hit/respawn got %b%b%b expected 110", ifc.game_over, ifc.hit, ifc.frog_respawn); end
        ifc.lane_pixels[19] = 1'b1;
        for (int i = 0; i < 50; i++) begin
            cycles(1);
            if (ifc.game_over !== 1'b1 || ifc.hit !== 1'b1 || ifc.lives !== 2'd0) bad++;
        end
        ifc.lane_pixels = '0;
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL go_terminal: bad cycles got %0d expected 0", bad); end
    endtask

    task automatic test_reset_priority();
        do_reset();
        collide();
        cycles(500);
        n_checks++; if (ifc.frog_respawn !== 1'b1) begin n_fail++; $display("FAIL rp_in_respawn: got %b expected 1", ifc.frog_respawn); end
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        n_checks++; if (ifc.hit !== 1'b0 || ifc.frog_respawn !== 1'b0 || ifc.game_over !== 1'b0 || ifc.lives !== 2'd3) begin n_fail++; $display("FAIL rp_respawn_reset: hit/resp/go got %b%b%b lives %0d expected 000 lives 3", ifc.hit, ifc.frog_respawn, ifc.game_over, ifc.lives); end
        collide(); cycles(1025);
        collide(); cycles(1025);
        collide(); cycles(1);
        n_checks++; if (ifc.game_over !== 1'b1) begin n_fail++; $display("FAIL rp_reach_dead: game_over got %b expected 1", ifc.game_over); end
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        n_checks++; if (ifc.hit !== 1'b0 || ifc.frog_respawn !== 1'b0 || ifc.game_over !== 1'b0 || ifc.lives !== 2'd3) begin n_fail++; $display("FAIL rp_dead_reset: hit/resp/go got %b%b%b lives %0d expected 000 lives 3", ifc.hit, ifc.frog_respawn, ifc.game_over, ifc.lives); end
        // Reset lands on the edge that would have entered HIT
        ifc.frog_row = 4'd9;
        ifc.frog_col = 4'd3;
        ifc.lane_pixels[19] = 1'b1;
        cycles(1);
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        n_checks++; if (ifc.hit !== 1'b0) begin n_fail++; $display("FAIL rp_same_cycle_hit: hit got %b expected 0", ifc.hit); end
        cycles(1);
        n_checks++; if (ifc.hit !== 1'b0) begin n_fail++; $display("FAIL rp_counter_cleared: hit got %b expected 0", ifc.hit); end
        cycles(1);
        n_checks++; if (ifc.hit !== 1'b1) begin n_fail++; $display("FAIL rp_hit_after_reset: hit got %b expected 1", ifc.hit); end
        ifc.lane_pixels = '0;
    endtask

`ifdef FROG_INVULN_EN
    task automatic test_invuln();
        int bad;
        bad = 0;
        do_reset();
        ifc.invuln = 1'b1;
        ifc.frog_row = 4'd9;
        ifc.frog_col = 4'd3;
        ifc.lane_pixels[19] = 1'b1;
        for (int i = 0; i < 50; i++) begin
            cycles(1);
            if (ifc.hit !== 1'b0) bad++;
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL invuln_no_hit: cycles with hit got %0d expected 0", bad); end
        ifc.invuln = 1'b0;
        cycles(1);
        n_checks++; if (ifc.hit !== 1'b0) begin n_fail++; $display("FAIL invuln_first: hit got %b expected 0", ifc.hit); end
        cycles(1);
        n_checks++; if (ifc.hit !== 1'b1) begin n_fail++; $display("FAIL invuln_release_hit: hit got %b expected 1", ifc.hit); end
        ifc.lane_pixels = '0;
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail = 0;
        reset = 1'b1;
        ifc.frog_row = '0;
        ifc.frog_col = '0;
        ifc.lane_pixels = '0;
`ifdef FROG_INVULN_EN
        ifc.invuln = 1'b0;
`endif
        test_reset();
        test_single_hit();
        test_alternating();
        test_lane_bounds();
        test_game_over();
        test_reset_priority();
`ifdef FROG_INVULN_EN
        test_invuln();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/frog_collide.md
FROG_COLLIDE -- requirements
Module: frog_collide

Interface
REQ-001 Parameter LIVES, default 3: lives at reset; legal range 1..3.
REQ-002 Parameter HIT_CYCLES, default 2: consecutive overlap cycles needed to register a hit; legal range 1..15.
REQ-003 Parameter RESPAWN_CYCLES, default 1024: RESPAWN state duration in cycles; legal range 1..65535.
REQ-004 Parameter LANE_BASE, default 8: grid row of car lane 0; lanes occupy rows LANE_BASE..LANE_BASE+7; legal range 0..8.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 frog_row  input  4  frog grid row, 0..15.
REQ-008 frog_col  input  4  frog grid column, 0..15.
REQ-009 lane_pixels  input  128  eight 16-bit car lane pixel rows; lane n occupies bits [16n+15:16n]; bit c is column c; 1 = car.
REQ-010 hit  output  1  collision indication to every car lane; level signal.
REQ-011 frog_respawn  output  1  high while frog must be held at start position.
REQ-012 game_over  output  1  high once all lives are lost.
REQ-013 lives  output  2  remaining lives.

Function
REQ-014 overlap SHALL be combinational: 1 iff LANE_BASE <= frog_row <= LANE_BASE+7 and lane_pixels[16*(frog_row-LANE_BASE)+frog_col] = 1; otherwise 0.
REQ-015 The FSM SHALL have exactly four states: RUN, HIT, RESPAWN, DEAD.
REQ-016 In RUN, a 4-bit overlap counter SHALL increment each cycle overlap=1 and clear to 0 on any cycle overlap=0.
REQ-017 RUN SHALL go to HIT on the cycle the counter reaches HIT_CYCLES, i.e. the clock edge that samples the HIT_CYCLES-th consecutive overlap; counter clears on that transition.
REQ-018 A frog moving off a car, or a car moving off the frog, mid-count SHALL clear the counter with no hit.
REQ-019 HIT SHALL last exactly one cycle and decrement lives by 1.
REQ-020 HIT SHALL go to DEAD if lives was 1 on entry; otherwise to RESPAWN.
REQ-021 RESPAWN SHALL run a 16-bit counter from 0 and go to RUN after exactly RESPAWN_CYCLES cycles in RESPAWN; the counter clears on exit.
REQ-022 DEAD SHALL be terminal until reset.
REQ-023 hit SHALL be 1 in HIT, RESPAWN and DEAD, and 0 in RUN.
REQ-024 hit SHALL stay high for at least RESPAWN_CYCLES+1 cycles, so a lane receiving a simultaneous one-cycle advance pulse still sees it.
REQ-025 frog_respawn SHALL be 1 only in RESPAWN.
REQ-026 game_over SHALL be 1 only in DEAD.
REQ-027 lives SHALL never wrap below 0.
REQ-028 Overlap SHALL be ignored outside RUN.
REQ-029 All outputs SHALL be registered or decoded only from registered state; no combinational path from inputs to outputs.

Reset
REQ-030 reset=1 at a clock edge SHALL force state RUN, lives=LIVES, both counters 0, hit=0, frog_respawn=0, game_over=0, regardless of current state.
REQ-031 reset SHALL take priority over every transition, including a same-cycle HIT entry.

Configuration
REQ-032 With macro FROG_INVULN_EN defined, input invuln (1 bit) SHALL exist; invuln=1 in RUN SHALL hold the overlap counter at 0, so no hit can occur.
REQ-033 With FROG_INVULN_EN undefined, port invuln and its logic SHALL be absent; behaviour as REQ-014..031.

Verification
REQ-034 Reset, frog_row=9, frog_col=3, lane 1 bit 3 set for 2 cycles -> hit=1 on the next cycle, lives 3->2, frog_respawn=1 one cycle later for 1024 cycles, then RUN with hit=0.
REQ-035 Overlap pulses alternate 1,0,1,0 for 20 cycles with HIT_CYCLES=2 -> hit stays 0, lives stays 3.
REQ-036 Three full collisions, each after the previous respawn -> lives 3,2,1,0; after the third HIT, game_over=1 and hit=1 indefinitely, ignoring further overlap.
REQ-037 Frog at row 5 (non-road) with all lane_pixels=1 for 100 cycles -> no hit; frog at row 15, col 15, bit 127 set -> hit.
REQ-038 Reset asserted in RESPAWN cycle 500 and again in DEAD -> next cycle state RUN, lives=3, all outputs 0.
REQ-039 FROG_INVULN_EN defined, invuln=1 with continuous overlap for 50 cycles -> no hit; invuln falls -> hit after HIT_CYCLES more overlap cycles.
